// File: rtl/fe_predict_stage.sv
// Fetch stage: owns the PC and the FE pipeline latch, and when FE_PREDICT_EN is
// defined, steers fetch with a gshare direction predictor plus a tagged BTB.
module fe_predict_stage #(
    parameter int               DBITS        = 32,
    parameter int               INSTSIZE     = 4,
    parameter logic [DBITS-1:0] STARTPC      = 32'h100,
    parameter int               PT_IDX_BITS  = 8,
    parameter int               BTB_IDX_BITS = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_stall_in,
    output logic [DBITS-1:0]       o_imem_addr,
    input  logic [31:0]            i_imem_rdata,
    input  logic                   i_upd_valid,
    input  logic [DBITS-1:0]       i_upd_pc,
    input  logic                   i_upd_taken,
    input  logic [DBITS-1:0]       i_upd_target,
    input  logic [PT_IDX_BITS-1:0] i_upd_pt_idx,
    input  logic                   i_mispred,
    input  logic [DBITS-1:0]       i_redirect_pc,
    output logic                   o_out_valid,
    output logic [31:0]            o_out_inst,
    output logic [DBITS-1:0]       o_out_pc,
    output logic [DBITS-1:0]       o_out_pcplus,
    output logic                   o_out_pred_taken,
    output logic [DBITS-1:0]       o_out_pred_target,
    output logic [PT_IDX_BITS-1:0] o_out_pt_idx,
    output logic [DBITS-1:0]       o_out_count
);

    logic [DBITS-1:0]       r_pc;
    logic [DBITS-1:0]       r_count;
    logic                   r_valid;
    logic [31:0]            r_inst;
    logic [DBITS-1:0]       r_out_pc;
    logic [DBITS-1:0]       r_out_pcplus;
    logic                   r_pred_taken;
    logic [DBITS-1:0]       r_pred_target;
    logic [PT_IDX_BITS-1:0] r_pt_idx;
    logic [DBITS-1:0]       r_out_count;

    logic [DBITS-1:0]       w_pcplus;
    logic                   w_pred_taken;
    logic [DBITS-1:0]       w_pred_next;
    logic [PT_IDX_BITS-1:0] w_pt_idx;

    assign w_pcplus = r_pc + DBITS'(INSTSIZE);

`ifdef FE_PREDICT_EN
    localparam int PT_ENTRIES  = 1 << PT_IDX_BITS;
    localparam int BTB_ENTRIES = 1 << BTB_IDX_BITS;
    localparam int TAG_BITS    = DBITS - BTB_IDX_BITS - 2;

    logic [1:0]             r_pt         [PT_ENTRIES];
    logic [PT_IDX_BITS-1:0] r_bhr;
    logic                   r_btb_valid  [BTB_ENTRIES];
    logic [TAG_BITS-1:0]    r_btb_tag    [BTB_ENTRIES];
    logic [DBITS-1:0]       r_btb_target [BTB_ENTRIES];

    logic [BTB_IDX_BITS-1:0] w_btb_idx;
    logic [TAG_BITS-1:0]     w_tag;
    logic [BTB_IDX_BITS-1:0] w_upd_btb_idx;
    logic [TAG_BITS-1:0]     w_upd_tag;
    logic [1:0]              w_upd_ctr;
    logic                    w_unused_upd_bits;

    assign w_pt_idx          = r_pc[PT_IDX_BITS+1:2] ^ r_bhr;
    assign w_btb_idx         = r_pc[BTB_IDX_BITS+1:2];
    assign w_tag             = r_pc[DBITS-1:BTB_IDX_BITS+2];
    assign w_upd_btb_idx     = i_upd_pc[BTB_IDX_BITS+1:2];
    assign w_upd_tag         = i_upd_pc[DBITS-1:BTB_IDX_BITS+2];
    assign w_upd_ctr         = r_pt[i_upd_pt_idx];
    assign w_unused_upd_bits = ^i_upd_pc[1:0];

    // Taken only when the counter leans taken and the BTB holds a matching target
    assign w_pred_taken = r_pt[w_pt_idx][1] && r_btb_valid[w_btb_idx]
                          && (r_btb_tag[w_btb_idx] == w_tag);
    assign w_pred_next  = w_pred_taken ? r_btb_target[w_btb_idx] : w_pcplus;

    // Predictor training from AGEX resolution; history is non-speculative
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bhr <= '0;
            for (int i = 0; i < PT_ENTRIES; i++) begin
                r_pt[i] <= 2'b01;
            end
            for (int j = 0; j < BTB_ENTRIES; j++) begin
                r_btb_valid[j] <= 1'b0;
            end
        end else if (i_upd_valid) begin
            r_bhr <= {r_bhr[PT_IDX_BITS-2:0], i_upd_taken};
            if (i_upd_taken) begin
                if (w_upd_ctr != 2'b11) begin
                    r_pt[i_upd_pt_idx] <= w_upd_ctr + 2'b01;
                end
                r_btb_valid[w_upd_btb_idx]  <= 1'b1;
                r_btb_tag[w_upd_btb_idx]    <= w_upd_tag;
                r_btb_target[w_upd_btb_idx] <= i_upd_target;
            end else if (w_upd_ctr != 2'b00) begin
                r_pt[i_upd_pt_idx] <= w_upd_ctr - 2'b01;
            end
        end
    end
`else
    logic w_unused_upd;

    assign w_pred_taken = 1'b0;
    assign w_pred_next  = w_pcplus;
    assign w_pt_idx     = '0;
    assign w_unused_upd = ^{i_upd_valid, i_upd_pc, i_upd_taken, i_upd_target, i_upd_pt_idx};
`endif

    // PC register and FE latch: reset > redirect > stall > advance
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc          <= STARTPC;
            r_count       <= DBITS'(1);
            r_valid       <= 1'b0;
            r_inst        <= 32'h0;
            r_out_pc      <= '0;
            r_out_pcplus  <= '0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
            r_pt_idx      <= '0;
            r_out_count   <= '0;
        end else if (i_mispred) begin
            r_pc    <= i_redirect_pc;
            r_valid <= 1'b0;
        end else if (i_stall_in) begin
            r_pc    <= r_pc;
            r_valid <= r_valid;
        end else begin
            r_pc          <= w_pred_next;
            r_count       <= r_count + DBITS'(1);
            r_valid       <= 1'b1;
            r_inst        <= i_imem_rdata;
            r_out_pc      <= r_pc;
            r_out_pcplus  <= w_pcplus;
            r_pred_taken  <= w_pred_taken;
            r_pred_target <= w_pred_next;
            r_pt_idx      <= w_pt_idx;
            r_out_count   <= r_count;
        end
    end

    assign o_imem_addr       = r_pc;
    assign o_out_valid       = r_valid;
    assign o_out_inst        = r_inst;
    assign o_out_pc          = r_out_pc;
    assign o_out_pcplus      = r_out_pcplus;
    assign o_out_pred_taken  = r_pred_taken;
    assign o_out_pred_target = r_pred_target;
    assign o_out_pt_idx      = r_pt_idx;
    assign o_out_count       = r_out_count;

endmodule

// File: tb/tb_fe_predict_stage.sv
// Self-checking bench for fe_predict_stage: directed test-plan steps followed by a
// randomized phase, all compared against an arithmetic model of the fetch stage.
module tb_fe_predict_stage;

`ifdef FE_PREDICT_EN
    localparam bit PRED = 1'b1;
`else
    localparam bit PRED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, stall_in, upd_valid, upd_taken, mispred;
    logic [31:0] imem_addr, imem_rdata, upd_pc, upd_target, redirect_pc;
    logic [7:0]  upd_pt_idx;
    logic        out_valid, out_pred_taken;
    logic [31:0] out_inst, out_pc, out_pcplus, out_pred_target, out_count;
    logic [7:0]  out_pt_idx;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit [31:0] m_pc;
    bit [31:0] m_count;
    bit        m_valid;
    bit [31:0] m_inst, m_opc, m_opcplus, m_ptgt, m_ocount;
    bit        m_ptaken;
    bit [31:0] m_ptidx;
    int        pt [256];
    int        bhr;
    bit        btb_v   [16];
    bit [31:0] btb_tag [16];
    bit [31:0] btb_tgt [16];

    always #5 clk = ~clk;

    assign imem_rdata = {imem_addr[15:0], ~imem_addr[31:16]};

    fe_predict_stage dut (
        .i_clk(clk), .i_reset(reset), .i_stall_in(stall_in),
        .o_imem_addr(imem_addr), .i_imem_rdata(imem_rdata),
        .i_upd_valid(upd_valid), .i_upd_pc(upd_pc), .i_upd_taken(upd_taken),
        .i_upd_target(upd_target), .i_upd_pt_idx(upd_pt_idx),
        .i_mispred(mispred), .i_redirect_pc(redirect_pc),
        .o_out_valid(out_valid), .o_out_inst(out_inst), .o_out_pc(out_pc),
        .o_out_pcplus(out_pcplus), .o_out_pred_taken(out_pred_taken),
        .o_out_pred_target(out_pred_target), .o_out_pt_idx(out_pt_idx),
        .o_out_count(out_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("imem_addr", imem_addr, m_pc);
        check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        if (m_valid) begin
            check("out_inst", out_inst, m_inst);
            check("out_pc", out_pc, m_opc);
            check("out_pcplus", out_pcplus, m_opcplus);
            check("out_pred_taken", {31'b0, out_pred_taken}, {31'b0, m_ptaken});
            check("out_pred_target", out_pred_target, m_ptgt);
            check("out_pt_idx", {24'b0, out_pt_idx}, m_ptidx);
            check("out_count", out_count, m_ocount);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare on the falling edge
    task automatic tick(input bit rst, input bit stall, input bit misp, input bit [31:0] redir,
                        input bit uv, input bit [31:0] upc, input bit ut,
                        input bit [31:0] utgt, input bit [7:0] uidx);
        int        idx, b;
        bit        taken;
        bit [31:0] nxt;
        reset = rst; stall_in = stall; mispred = misp; redirect_pc = redir;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt; upd_pt_idx = uidx;

        idx   = ((m_pc >> 2) % 256) ^ bhr;
        b     = (m_pc >> 2) % 16;
        taken = PRED && (pt[idx] >= 2) && btb_v[b] && (btb_tag[b] == (m_pc >> 6));
        nxt   = taken ? btb_tgt[b] : m_pc + 32'd4;

        if (rst) begin
            m_pc = 32'h100; m_count = 32'd1; m_valid = 1'b0;
            m_inst = 0; m_opc = 0; m_opcplus = 0; m_ptaken = 0; m_ptgt = 0; m_ptidx = 0; m_ocount = 0;
            bhr = 0;
            foreach (pt[i]) pt[i] = 1;
            foreach (btb_v[i]) btb_v[i] = 1'b0;
        end else begin
            if (misp) begin
                m_pc = redir; m_valid = 1'b0;
            end else if (!stall) begin
                m_valid = 1'b1; m_inst = {m_pc[15:0], ~m_pc[31:16]};
                m_opc = m_pc; m_opcplus = m_pc + 32'd4; m_ptaken = taken; m_ptgt = nxt;
                m_ptidx = PRED ? idx : 0; m_ocount = m_count;
                m_count = m_count + 32'd1; m_pc = nxt;
            end
            if (PRED && uv) begin
                if (ut) pt[uidx] = (pt[uidx] == 3) ? 3 : pt[uidx] + 1;
                else    pt[uidx] = (pt[uidx] == 0) ? 0 : pt[uidx] - 1;
                bhr = ((bhr << 1) | int'(ut)) % 256;
                if (ut) begin
                    btb_v[(upc >> 2) % 16]   = 1'b1;
                    btb_tag[(upc >> 2) % 16] = upc >> 6;
                    btb_tgt[(upc >> 2) % 16] = utgt;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic nop();
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic train(input bit ut, input bit [7:0] uidx);
        tick(0, 0, 0, 0, 1, 32'h120, ut, 32'h300, uidx);
    endtask

    initial begin
        bit [31:0] held_pc, held_cnt;
        m_pc = 0; bhr = 0;
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_count", out_count, 32'd0);
        check("rst_addr", imem_addr, 32'h100);

        // Sequential fetch after reset
        nop(); check("seq_pc0", out_pc, 32'h100); check("seq_cnt0", out_count, 32'd1);
        nop(); check("seq_pc1", out_pc, 32'h104); check("seq_cnt1", out_count, 32'd2);
        nop(); check("seq_pc2", out_pc, 32'h108); check("seq_cnt2", out_count, 32'd3);
        check("seq_valid", {31'b0, out_valid}, 32'd1);
        check("seq_pred", {31'b0, out_pred_taken}, 32'd0);

        // Stall holds everything
        held_pc = out_pc; held_cnt = out_count;
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("stall_pc", out_pc, held_pc);
        check("stall_cnt", out_count, held_cnt);
        check("stall_addr", imem_addr, 32'h10C);

        // Redirect wins over stall
        tick(0, 1, 1, 32'h200, 0, 0, 0, 0, 0);
        check("misp_valid", {31'b0, out_valid}, 32'd0);
        check("misp_addr", imem_addr, 32'h200);
        nop(); check("misp_pc", out_pc, 32'h200);

        // Two taken updates for 0x120, then refetch it
        train(1, 8'h4B); train(1, 8'h4B);
        tick(0, 0, 1, 32'h118, 0, 0, 0, 0, 0);
        nop(); nop(); nop();
        check("btb_pc", out_pc, 32'h120);
        check("btb_taken", {31'b0, out_pred_taken}, {31'b0, PRED});
        check("btb_target", out_pred_target, PRED ? 32'h300 : 32'h124);
        check("btb_next", imem_addr, PRED ? 32'h300 : 32'h124);

        // Saturation: 5 taken + 1 not-taken still predicts taken
        for (int i = 0; i < 5; i++) train(1, 8'hB6);
        train(0, 8'hB6);
        tick(0, 0, 1, 32'h11C, 0, 0, 0, 0, 0);
        nop(); nop();
        check("sat_pc", out_pc, 32'h120);
        check("sat_taken", {31'b0, out_pred_taken}, {31'b0, PRED});
        train(0, 8'hB6); train(0, 8'hB6);
        tick(0, 0, 1, 32'h11C, 0, 0, 0, 0, 0);
        nop(); nop();
        check("nt_pc", out_pc, 32'h120);
        check("nt_taken", {31'b0, out_pred_taken}, 32'd0);
        check("nt_next", imem_addr, 32'h124);

        // Randomized traffic in a small PC window so the BTB actually hits
        for (int i = 0; i < 400; i++) begin
            bit        rs, st, mp, uv, ut;
            bit [31:0] rd, up, tg;
            bit [7:0]  ix;
            rs = (i == 200);
            st = ($urandom % 5) == 0;
            mp = ($urandom % 16) == 0;
            rd = 32'h100 + (($urandom % 32) << 2);
            uv = ($urandom % 3) == 0;
            up = 32'h100 + (($urandom % 32) << 2);
            ut = $urandom % 2;
            tg = 32'h100 + (($urandom % 32) << 2);
            ix = ($urandom % 4 == 0) ? 8'($urandom) : 8'(((up >> 2) % 256) ^ bhr);
            tick(rs, st, mp, rd, uv, up, ut, tg, ix);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fe_predict_stage.md
# fe_predict_stage

Parametrised successor to the fetch stage: owns the PC register and the FE pipeline latch, and adds an internal gshare direction predictor (BHR + pattern table of 2-bit counters) plus a tagged BTB, so taken branches are steered at fetch instead of waiting for AGEX redirect. It sits between the instruction memory and the DE stage; AGEX feeds back resolution/update and misprediction redirect.

## Interface
- DBITS, 32, PC/data width
- INSTSIZE, 4, bytes per instruction
- STARTPC, 32'h100, PC loaded on reset
- PT_IDX_BITS, 8, log2 pattern-table entries; also BHR width
- BTB_IDX_BITS, 4, log2 BTB entries
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- stall_in  in  1  DE stall; hold PC and latch
- imem_addr  out  DBITS  current fetch PC (pc_q)
- imem_rdata  in  32  instruction at imem_addr, combinational
- upd_valid  in  1  AGEX resolved a branch/jump this cycle
- upd_pc  in  DBITS  PC of resolved instruction
- upd_taken  in  1  actual direction
- upd_target  in  DBITS  actual target
- upd_pt_idx  in  PT_IDX_BITS  PT index carried with the instruction
- mispred  in  1  redirect fetch
- redirect_pc  in  DBITS  correct next PC
- out_valid  out  1  latch holds a real instruction
- out_inst  out  32  latched instruction
- out_pc, out_pcplus  out  DBITS  latched PC, PC+INSTSIZE
- out_pred_taken  out  1  prediction made at fetch
- out_pred_target  out  DBITS  predicted next PC
- out_pt_idx  out  PT_IDX_BITS  index used, for later update
- out_count  out  DBITS  fetch sequence number (debug)

## Operation
- Index: pt_idx = pc_q[PT_IDX_BITS+1:2] ^ bhr; btb_idx = pc_q[BTB_IDX_BITS+1:2]; tag = pc_q[DBITS-1:BTB_IDX_BITS+2].
- Predict taken iff PT[pt_idx] >= 2 AND BTB valid AND tag match; pred_next = BTB target, else pc_q+INSTSIZE.
- PC priority per edge: reset > mispred (pc_q <= redirect_pc) > stall_in (hold) > advance (pc_q <= pred_next).
- Latch priority: reset (all zero) > mispred (out_valid <= 0, other fields don't-care) > stall_in (hold) > capture {1, imem_rdata, pc_q, pc_q+INSTSIZE, pred, pred_next, pt_idx, count}.
- out_count: reset 1; increments only on advance capture.
- Update on upd_valid, independent of stall_in/mispred: PT[upd_pt_idx] saturating ±1 (0..3) by upd_taken; bhr <= {bhr[PT_IDX_BITS-2:0], upd_taken} (non-speculative); if upd_taken, BTB[upd_pc idx] <= {valid=1, tag, upd_target}.
- Reset: pc_q=STARTPC, bhr=0, all PT=2'b01 (weakly not-taken), all BTB valid=0, latch zero, out_valid=0, out_count=0 until first capture loads 1.
- PC+INSTSIZE wraps modulo 2^DBITS.

## Timing
- Prediction combinational from pc_q; result in latch one edge later.
- Updates written at edge; visible to predictions from next cycle. Same-cycle read of an entry being updated returns old value (no bypass).
- mispred with stall_in simultaneously: redirect wins, latch invalidated.
- Reset mid-operation discards all predictor state.

## Configuration
- FE_PREDICT_EN defined: gshare + BTB as above.
- Undefined: no PT/BTB/BHR storage; out_pred_taken=0, pred_next=pc_q+INSTSIZE, out_pt_idx=0; upd_* ignored; PC/latch/redirect/stall behaviour unchanged.

## Test plan
- Reset, no stall, 4 cycles -> out_pc 0x100,0x104,0x108 with out_count 1,2,3, out_valid=1, out_pred_taken=0.
- stall_in high 3 cycles at pc 0x108 -> imem_addr and all out_* held constant; count not incremented.
- mispred redirect_pc=0x200 with stall_in=1 -> next cycle out_valid=0, imem_addr=0x200; following capture out_pc=0x200.
- Two upd_valid taken updates for pc 0x120 target 0x300 (same pt_idx, bhr accounted) -> fetch at 0x120 yields out_pred_taken=1, out_pred_target=0x300, next imem_addr=0x300.
- PT saturation: 5 taken then 1 not-taken update on one index -> counter 3 then 2, still predicts taken; two more not-taken -> predicts not-taken.
- Build without FE_PREDICT_EN, repeat previous scenario -> out_pred_taken=0, sequential PCs.
